// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache with 256-bit lines.
// A miss stalls the pipeline while the FSM writes back a dirty victim and refills the line.
module dcache_controller #(
    parameter int INDEX_BITS = 5
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [31:0]  p1_addr_i,
    input  logic [31:0]  p1_data_i,
    input  logic         p1_MemRead_i,
    input  logic         p1_MemWrite_i,
    output logic [31:0]  p1_data_o,
    output logic         p1_stall_o,
    input  logic [255:0] mem_data_i,
    input  logic         mem_ack_i,
    output logic [255:0] mem_data_o,
    output logic [31:0]  mem_addr_o,
    output logic         mem_enable_o,
    output logic         mem_write_o
);
    localparam int OFFSET_BITS = 5;
    localparam int LINES       = 1 << INDEX_BITS;
    localparam int TAG_BITS    = 32 - OFFSET_BITS - INDEX_BITS;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        MISS       = 3'd1,
        READMISS   = 3'd2,
        READMISSOK = 3'd3,
        WRITEBACK  = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [LINES-1:0]      valid_q, valid_d;
    logic [LINES-1:0]      dirty_q, dirty_d;
    logic [TAG_BITS-1:0]   tag_q  [LINES];
    logic [255:0]          data_q [LINES];

    logic [INDEX_BITS-1:0] idx_s;
    logic [TAG_BITS-1:0]   req_tag_s;
    logic [TAG_BITS-1:0]   line_tag_s;
    logic [2:0]            word_s;
    logic [255:0]          line_s;
    logic [255:0]          wline_s;
    logic                  req_s;
    logic                  hit_s;
    logic                  data_we_s;
    logic                  tag_we_s;
    logic                  unused_s;

    assign idx_s      = p1_addr_i[OFFSET_BITS +: INDEX_BITS];
    assign req_tag_s  = p1_addr_i[31 -: TAG_BITS];
    assign word_s     = p1_addr_i[4:2];
    assign line_s     = data_q[idx_s];
    assign line_tag_s = tag_q[idx_s];
    assign req_s      = p1_MemRead_i | p1_MemWrite_i;
    assign hit_s      = valid_q[idx_s] & (line_tag_s == req_tag_s);
    assign unused_s   = ^p1_addr_i[1:0];

    // State and line status registers; reset drops every line and any miss in flight.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            valid_q <= {LINES{1'b0}};
            dirty_q <= {LINES{1'b0}};
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tag and data arrays; not cleared by reset, only their valid bits are.
    always_ff @(posedge clk_i) begin
        if (rst_i && data_we_s) begin
            data_q[idx_s] <= wline_s;
        end
        if (rst_i && tag_we_s) begin
            tag_q[idx_s] <= req_tag_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (req_s && !hit_s) state_d = MISS; else state_d = IDLE;
            MISS:       if (valid_q[idx_s] && dirty_q[idx_s]) state_d = WRITEBACK;
                        else state_d = READMISS;
            WRITEBACK:  if (mem_ack_i) state_d = READMISS; else state_d = WRITEBACK;
            READMISS:   if (mem_ack_i) state_d = READMISSOK; else state_d = READMISS;
            READMISSOK: state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // DRAM request outputs decoded from the state.
    always_comb begin
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = 32'd0;
        mem_data_o   = 256'd0;
        case (state_q)
            WRITEBACK: begin
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {line_tag_s, idx_s, 5'b00000};
                mem_data_o   = line_s;
            end
            READMISS: begin
                mem_enable_o = 1'b1;
                mem_addr_o   = {req_tag_s, idx_s, 5'b00000};
            end
            default: mem_enable_o = 1'b0;
        endcase
    end

    // Pipeline-side outputs.
    always_comb begin
        p1_stall_o = req_s & ~hit_s;
        if (p1_MemRead_i) begin
            p1_data_o = line_s[{word_s, 5'b00000} +: 32];
        end else begin
            p1_data_o = 32'd0;
        end
    end

    // Array updates: refill data lands on the ack, but the tag only goes valid one
    // cycle later, so the request still stalls in READMISSOK and then hits in IDLE.
    always_comb begin
        valid_d   = valid_q;
        dirty_d   = dirty_q;
        data_we_s = 1'b0;
        tag_we_s  = 1'b0;
        wline_s   = line_s;
        if (state_q == IDLE && p1_MemWrite_i && hit_s) begin
            data_we_s                          = 1'b1;
            wline_s[{word_s, 5'b00000} +: 32]  = p1_data_i;
            dirty_d[idx_s]                     = 1'b1;
        end else if (state_q == READMISS && mem_ack_i) begin
            data_we_s = 1'b1;
            wline_s   = mem_data_i;
        end else if (state_q == READMISSOK) begin
            tag_we_s       = 1'b1;
            valid_d[idx_s] = 1'b1;
            dirty_d[idx_s] = 1'b0;
        end else begin
            data_we_s = 1'b0;
        end
    end
endmodule
